// File: rtl/sync_pkg.sv
// -----------------------------------------------------------------------------
// sync_pkg
// Shared definitions for the detonator trigger controller:
//   - state_e     : controller FSM state encoding
//   - FAULT_*     : sticky fault codes driven on the 'fault' output
//   - *_DEF       : default parameter values for sync_trigger_ctrl
//   - DELAY_TIMEOUT_VAL : value reported on delay_cycles after a wire timeout
// -----------------------------------------------------------------------------
package sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARMED      = 3'd1,
    ST_WAIT_PHASE = 3'd2,
    ST_FIRE       = 3'd3,
    ST_WAIT_WIRE  = 3'd4
  } state_e;

  localparam logic [1:0] FAULT_NONE         = 2'd0;
  localparam logic [1:0] FAULT_NO_PHASE     = 2'd1;
  localparam logic [1:0] FAULT_WIRE_TIMEOUT = 2'd2;
  localparam logic [1:0] FAULT_ABORTED      = 2'd3;

  // 100 ns pulse, 10 ms wire window, 4 gate windows at 100 MHz.
  localparam int TRIG_PULSE_CYC_DEF   = 10;
  localparam int WIRE_TIMEOUT_CYC_DEF = 1_000_000;
  localparam int GATE_RETRY_DEF       = 4;

  localparam logic [31:0] DELAY_TIMEOUT_VAL = 32'hFFFF_FFFF;

endpackage

// File: rtl/sync_edge.sv
// -----------------------------------------------------------------------------
// sync_edge
// Two-flop synchronizer for one asynchronous input, followed by rise/fall
// detection on the synchronized value.
// Ports:
//   clk      : system clock
//   rst_n    : asynchronous active-low reset (clears all flops)
//   i_async  : asynchronous input
//   o_level  : synchronized level
//   o_rise   : one-cycle pulse, synchronized level went 0 -> 1
//   o_fall   : one-cycle pulse, synchronized level went 1 -> 0
// -----------------------------------------------------------------------------
module sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_sync & ~r_prev;
  assign o_fall  = ~r_sync & r_prev;

endmodule

// File: rtl/sync_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// sync_trigger_ctrl
// Arms on a start edge, waits for a fast-gate window, fires a fixed-width
// trigger pulse on the first phase edge inside the window, then measures the
// delay until the wire sensor responds.
// Ports:
//   clk, rst_n        : 100 MHz clock, asynchronous active-low reset
//   start_condition   : arm request (async, rising edge)
//   abort             : synchronous level abort (clk domain)
//   fast_gate         : gate window, high = open (async)
//   phase_signal      : phase reference (async, rising edge)
//   wire_sensor       : wire-break response (async, rising edge)
//   output_trigger    : detonator trigger pulse
//   busy              : high whenever the FSM is not idle
//   done              : one-cycle pulse on a wire_sensor capture
//   fault             : sticky fault code (see sync_pkg)
//   delay_cycles      : trigger-start to wire_sensor delay in clk cycles
//   o_dbg_state       : current FSM state
// -----------------------------------------------------------------------------
module sync_trigger_ctrl
  import sync_pkg::*;
#(
  parameter int TRIG_PULSE_CYC   = TRIG_PULSE_CYC_DEF,
  parameter int WIRE_TIMEOUT_CYC = WIRE_TIMEOUT_CYC_DEF,
  parameter int GATE_RETRY       = GATE_RETRY_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_condition,
  input  logic        abort,
  input  logic        fast_gate,
  input  logic        phase_signal,
  input  logic        wire_sensor,
  output logic        output_trigger,
  output logic        busy,
  output logic        done,
  output logic [1:0]  fault,
  output logic [31:0] delay_cycles,
  output state_e      o_dbg_state
);

  localparam logic [31:0] PULSE_LAST   = 32'(TRIG_PULSE_CYC - 1);
  localparam logic [31:0] TIMEOUT_LAST = 32'(WIRE_TIMEOUT_CYC - 1);
  localparam logic [7:0]  RETRY_LIMIT  = 8'(GATE_RETRY);

  // Synchronized inputs
  logic w_start_lvl, w_start_rise, w_start_fall;
  logic w_gate_lvl,  w_gate_rise,  w_gate_fall;
  logic w_phase_lvl, w_phase_rise, w_phase_fall;
  logic w_wire_lvl,  w_wire_rise,  w_wire_fall;
  logic w_unused;

  sync_edge u_sync_start (
    .clk(clk), .rst_n(rst_n), .i_async(start_condition),
    .o_level(w_start_lvl), .o_rise(w_start_rise), .o_fall(w_start_fall)
  );
  sync_edge u_sync_gate (
    .clk(clk), .rst_n(rst_n), .i_async(fast_gate),
    .o_level(w_gate_lvl), .o_rise(w_gate_rise), .o_fall(w_gate_fall)
  );
  sync_edge u_sync_phase (
    .clk(clk), .rst_n(rst_n), .i_async(phase_signal),
    .o_level(w_phase_lvl), .o_rise(w_phase_rise), .o_fall(w_phase_fall)
  );
  sync_edge u_sync_wire (
    .clk(clk), .rst_n(rst_n), .i_async(wire_sensor),
    .o_level(w_wire_lvl), .o_rise(w_wire_rise), .o_fall(w_wire_fall)
  );

  assign w_unused = ^{w_start_lvl, w_start_fall, w_phase_lvl, w_phase_fall,
                      w_wire_lvl, w_wire_fall};

  state_e      r_state, w_state_nxt;
  logic [31:0] r_cnt;      // counts from 0 on the first trigger-high cycle
  logic [7:0]  r_retry;    // gate windows closed without a phase edge
  logic [1:0]  r_fault;
  logic [31:0] r_delay;
  logic        r_done;

  // FSM events. A gate fall makes the synchronized level low in the same
  // cycle, so a phase edge coinciding with a gate fall is a miss, not a fire.
  logic w_abort_evt, w_fire_evt, w_miss_evt, w_retry_out;
  logic w_pulse_end, w_capture, w_timeout;

  assign w_abort_evt = abort && (r_state != ST_IDLE);
  assign w_fire_evt  = (r_state == ST_WAIT_PHASE) && w_phase_rise && w_gate_lvl;
  assign w_miss_evt  = (r_state == ST_WAIT_PHASE) && w_gate_fall;
  assign w_retry_out = w_miss_evt && ((r_retry + 8'd1) == RETRY_LIMIT);
  assign w_pulse_end = (r_state == ST_FIRE) && (r_cnt == PULSE_LAST);
  assign w_capture   = (r_state == ST_WAIT_WIRE) && w_wire_rise;
  // Leaving on count N-1 makes the fault visible exactly N cycles after the
  // trigger went high, the same edge the counter would reach N.
  assign w_timeout   = (r_state == ST_WAIT_WIRE) && !w_wire_rise &&
                       (r_cnt == TIMEOUT_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    if (w_abort_evt) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:       if (w_start_rise) w_state_nxt = ST_ARMED;
        ST_ARMED:      if (w_gate_rise)  w_state_nxt = ST_WAIT_PHASE;
        ST_WAIT_PHASE: begin
          if (w_fire_evt)      w_state_nxt = ST_FIRE;
          else if (w_miss_evt) w_state_nxt = w_retry_out ? ST_IDLE : ST_ARMED;
        end
        ST_FIRE:       if (w_pulse_end)  w_state_nxt = ST_WAIT_WIRE;
        ST_WAIT_WIRE:  if (w_capture || w_timeout) w_state_nxt = ST_IDLE;
        default:       w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Counters, fault and capture registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= 32'd0;
      r_retry <= 8'd0;
      r_fault <= FAULT_NONE;
      r_delay <= 32'd0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_abort_evt) begin
        r_fault <= FAULT_ABORTED;
      end else begin
        if ((r_state == ST_IDLE) && w_start_rise) begin
          r_fault <= FAULT_NONE;
          r_retry <= 8'd0;
        end
        if (w_fire_evt) begin
          r_cnt <= 32'd0;
        end else if ((r_state == ST_FIRE) || (r_state == ST_WAIT_WIRE)) begin
          r_cnt <= r_cnt + 32'd1;
        end
        if (w_miss_evt) begin
          r_retry <= r_retry + 8'd1;
          if (w_retry_out) r_fault <= FAULT_NO_PHASE;
        end
        if (w_capture) begin
          r_delay <= r_cnt;
          r_done  <= 1'b1;
        end
        if (w_timeout) begin
          r_fault <= FAULT_WIRE_TIMEOUT;
          r_delay <= DELAY_TIMEOUT_VAL;
        end
      end
    end
  end

  // Outputs. Abort gates the trigger combinationally so the pulse drops in
  // the abort cycle itself rather than one edge later.
  always_comb begin
    output_trigger = 1'b0;
    busy           = 1'b0;
    if ((r_state == ST_FIRE) && !abort) output_trigger = 1'b1;
    if (r_state != ST_IDLE)             busy           = 1'b1;
  end

  assign done         = r_done;
  assign fault        = r_fault;
  assign delay_cycles = r_delay;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_sync_trigger_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sync_trigger_ctrl
// Scaled-down timing: gate open 40 of every 400 cycles, phase period 12
// cycles, wire timeout 3000 cycles. Inputs change on falling clock edges;
// outputs are sampled 1 ns after rising edges.
// -----------------------------------------------------------------------------
module tb_sync_trigger_ctrl;
  import sync_pkg::*;

  localparam int P_PULSE     = 10;
  localparam int P_TMO       = 3000;
  localparam int P_RETRY     = 4;
  localparam int GATE_PERIOD = 400;
  localparam int GATE_OPEN   = 40;
  localparam int PH_HALF     = 6;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic        start_condition, abort, fast_gate, phase_signal, wire_sensor;
  logic        output_trigger, busy, done;
  logic [1:0]  fault;
  logic [31:0] delay_cycles;
  state_e      dbg_state;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sync_trigger_ctrl #(
    .TRIG_PULSE_CYC  (P_PULSE),
    .WIRE_TIMEOUT_CYC(P_TMO),
    .GATE_RETRY      (P_RETRY)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start_condition(start_condition),
    .abort          (abort),
    .fast_gate      (fast_gate),
    .phase_signal   (phase_signal),
    .wire_sensor    (wire_sensor),
    .output_trigger (output_trigger),
    .busy           (busy),
    .done           (done),
    .fault          (fault),
    .delay_cycles   (delay_cycles),
    .o_dbg_state    (dbg_state)
  );

  // ---------------- counters / check ----------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h (%0d) expected 0x%08h (%0d)", tag, act, act, exp, exp);
    end
  endtask

  // ---------------- background stimulus ----------------
  int gate_cnt = 0;
  bit phase_en = 1'b1;

  initial begin
    fast_gate = 1'b0;
    forever begin
      repeat (GATE_PERIOD - GATE_OPEN) @(negedge clk);
      fast_gate = 1'b1;
      gate_cnt++;
      repeat (GATE_OPEN) @(negedge clk);
      fast_gate = 1'b0;
    end
  end

  initial begin
    phase_signal = 1'b0;
    forever begin
      repeat (PH_HALF) @(negedge clk);
      phase_signal = phase_en ? ~phase_signal : 1'b0;
    end
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [1:0]  fault;
    logic [31:0] delay;
    int          pulse_len;
    int          n_trig;
    int          n_done;
    bit          chk_span;
    bit          chk_gate;
    int          trig_gate;
    bit          chk_end_gate;
    int          end_gate;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] m_delay = 32'd0;  // model of the held delay_cycles value

  int cyc = 0;
  int sb_events = 0;
  int tot_trig = 0;
  int acc_pulse = 0, acc_trig = 0, acc_done = 0;
  int trig_start_cyc = 0, trig_gate_seen = 0;
  logic prev_busy = 1'b0, prev_trig = 1'b0;

  function automatic exp_t mk_exp(input logic [1:0] f, input logic [31:0] d,
                                  input int pl, input int nt, input int nd);
    exp_t e;
    e.fault = f; e.delay = d; e.pulse_len = pl; e.n_trig = nt; e.n_done = nd;
    e.chk_span = 1'b0; e.chk_gate = 1'b0; e.trig_gate = 0;
    e.chk_end_gate = 1'b0; e.end_gate = 0;
    return e;
  endfunction

  task automatic score();
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_empty", exp_q.size(), 1);
    end else begin
      e = exp_q.pop_front();
      check("fault",     fault,        e.fault);
      check("delay",     delay_cycles, e.delay);
      check("pulse_len", acc_pulse,    e.pulse_len);
      check("n_trig",    acc_trig,     e.n_trig);
      check("n_done",    acc_done,     e.n_done);
      if (e.chk_span)     check("tmo_span",   cyc - trig_start_cyc, P_TMO);
      if (e.chk_gate)     check("trig_gate",  trig_gate_seen,       e.trig_gate);
      if (e.chk_end_gate) check("retry_gate", gate_cnt,             e.end_gate);
    end
    acc_pulse = 0; acc_trig = 0; acc_done = 0;
    sb_events++;
  endtask

  // Monitor: one sample per cycle, a sequence is scored when busy falls.
  always @(posedge clk) begin
    #1;
    cyc++;
    if (output_trigger) begin
      acc_pulse++;
      if (!prev_trig) begin
        acc_trig++;
        tot_trig++;
        trig_start_cyc = cyc;
        trig_gate_seen = gate_cnt;
      end
    end
    if (done) acc_done++;
    if (prev_busy && !busy) score();
    prev_busy = busy;
    prev_trig = output_trigger;
  end

  // ---------------- driver tasks ----------------
  task automatic pulse_start();
    start_condition = 1'b1;
    repeat (4) @(negedge clk);
    start_condition = 1'b0;
  endtask

  task automatic wait_trig(input string tag, input int budget);
    bit got = 1'b0;
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (output_trigger) got = 1'b1;
    end
    check(tag, got, 1);
  endtask

  task automatic wait_scored(input string tag, input int n0, input int budget);
    bit got = (sb_events != n0);
    for (int i = 0; i < budget && !got; i++) begin
      @(negedge clk);
      if (sb_events != n0) got = 1'b1;
    end
    check(tag, got, 1);
  endtask

  // Leave the bench just after a gate has closed (or inside an open gate).
  task automatic align_gate(input bit in_gate);
    while (fast_gate) @(negedge clk);
    if (in_gate) begin
      while (!fast_gate) @(negedge clk);
      repeat (5) @(negedge clk);
    end else begin
      repeat (20) @(negedge clk);
    end
  endtask

  // Full capture sequence. A short wire pulse during FIRE must be ignored, and
  // a start pulse during WAIT_WIRE must not re-arm. The wire edge driven D
  // cycles after the first trigger-high cycle is seen 2 cycles later through
  // the synchronizer, so the reported delay is D+2.
  task automatic run_nominal(input bit in_gate);
    int   d;
    int   n0;
    exp_t e;
    d = $urandom_range(1500, 200);
    align_gate(in_gate);
    e = mk_exp(FAULT_NONE, 32'(d + 2), P_PULSE, 1, 1);
    e.chk_gate  = 1'b1;
    e.trig_gate = gate_cnt + 1;
    exp_q.push_back(e);
    m_delay = 32'(d + 2);
    n0 = sb_events;
    pulse_start();
    wait_trig("nom_trig", 2 * GATE_PERIOD);
    wire_sensor = 1'b1;
    repeat (3) @(negedge clk);
    wire_sensor = 1'b0;
    repeat (47) @(negedge clk);
    pulse_start();
    repeat (d - 54) @(negedge clk);
    wire_sensor = 1'b1;
    wait_scored("nom_done", n0, 20);
    wire_sensor = 1'b0;
    repeat (30) @(negedge clk);
    check("no_rearm", busy, 0);
  endtask

  // ---------------- main sequence ----------------
  int   n0;
  int   t0;
  exp_t e;

  initial begin
    rst_n = 1'b0;
    start_condition = 1'b0;
    abort = 1'b0;
    wire_sensor = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_trig",  output_trigger, 0);
    check("rst_busy",  busy,           0);
    check("rst_done",  done,           0);
    check("rst_fault", fault,          FAULT_NONE);
    check("rst_delay", delay_cycles,   0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Nominal captures: start between gates, then start inside an open gate.
    run_nominal(1'b0);
    run_nominal(1'b1);
    run_nominal(1'b0);

    // Wire never arrives.
    align_gate(1'b0);
    e = mk_exp(FAULT_WIRE_TIMEOUT, DELAY_TIMEOUT_VAL, P_PULSE, 1, 0);
    e.chk_span = 1'b1;
    exp_q.push_back(e);
    m_delay = DELAY_TIMEOUT_VAL;
    n0 = sb_events;
    pulse_start();
    wait_trig("tmo_trig", 2 * GATE_PERIOD);
    wait_scored("tmo_end", n0, P_TMO + 100);

    // No phase edges: gives up after the last allowed gate window closes.
    phase_en = 1'b0;
    align_gate(1'b0);
    e = mk_exp(FAULT_NO_PHASE, m_delay, 0, 0, 0);
    e.chk_end_gate = 1'b1;
    e.end_gate     = gate_cnt + P_RETRY;
    exp_q.push_back(e);
    n0 = sb_events;
    pulse_start();
    wait_scored("nophase_end", n0, (P_RETRY + 1) * GATE_PERIOD);
    phase_en = 1'b1;

    // Abort while idle changes nothing.
    abort = 1'b1;
    repeat (3) @(negedge clk);
    abort = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_abort_fault", fault, FAULT_NO_PHASE);
    check("idle_abort_busy",  busy,  0);

    // Abort three cycles into FIRE: trigger drops in the abort cycle.
    align_gate(1'b0);
    exp_q.push_back(mk_exp(FAULT_ABORTED, m_delay, 4, 1, 0));
    n0 = sb_events;
    pulse_start();
    wait_trig("abort_trig", 2 * GATE_PERIOD);
    repeat (3) @(negedge clk);
    abort = 1'b1;
    #1;
    check("abort_trig_now", output_trigger, 0);
    @(negedge clk);
    check("abort_idle", busy, 0);
    abort = 1'b0;
    wait_scored("abort_end", n0, 20);

    // Reset in WAIT_WIRE, with a start pulse while busy beforehand.
    align_gate(1'b0);
    exp_q.push_back(mk_exp(FAULT_NONE, 32'd0, P_PULSE, 1, 0));
    m_delay = 32'd0;
    n0 = sb_events;
    pulse_start();
    wait_trig("rst1_trig", 2 * GATE_PERIOD);
    repeat (30) @(negedge clk);
    pulse_start();
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst1_trig_now",  output_trigger, 0);
    check("rst1_busy_now",  busy,           0);
    check("rst1_done_now",  done,           0);
    check("rst1_fault_now", fault,          FAULT_NONE);
    check("rst1_delay_now", delay_cycles,   0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_scored("rst1_end", n0, 20);
    t0 = tot_trig;
    repeat (2 * GATE_PERIOD) @(negedge clk);
    check("rst1_no_trig", tot_trig - t0, 0);
    check("rst1_idle",    busy,          0);

    // Reset mid-FIRE truncates the pulse at once.
    align_gate(1'b0);
    exp_q.push_back(mk_exp(FAULT_NONE, 32'd0, 5, 1, 0));
    n0 = sb_events;
    pulse_start();
    wait_trig("rst2_trig", 2 * GATE_PERIOD);
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("rst2_trig_now", output_trigger, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_scored("rst2_end", n0, 20);
    t0 = tot_trig;
    repeat (2 * GATE_PERIOD) @(negedge clk);
    check("rst2_no_trig", tot_trig - t0, 0);

    // Fresh start after reset runs the nominal sequence again.
    run_nominal(1'b0);

    check("sb_leftover", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, vectors %0d", n_vec);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sync_trigger_ctrl.md
SYNC_TRIGGER_CTRL -- requirements
Module: sync_trigger_ctrl

Interface
REQ-001 SHALL have parameter TRIG_PULSE_CYC, default 10, trigger pulse width in clk cycles (100 ns at 100 MHz).
REQ-002 SHALL have parameter WIRE_TIMEOUT_CYC, default 1_000_000, max wait for wire_sensor after trigger (10 ms).
REQ-003 SHALL have parameter GATE_RETRY, default 4, number of fast-gate windows allowed without a phase edge.
REQ-004 SHALL have clk  input  1  single system clock, 100 MHz.
REQ-005 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have start_condition  input  1  arm request, rising edge significant, asynchronous to clk.
REQ-007 SHALL have abort  input  1  synchronous abort, level, clk domain.
REQ-008 SHALL have fast_gate  input  1  gate window, high = open, asynchronous.
REQ-009 SHALL have phase_signal  input  1  phase reference (~819 kHz), rising edge significant, asynchronous.
REQ-010 SHALL have wire_sensor  input  1  wire-break response, rising edge significant, asynchronous.
REQ-011 SHALL have output_trigger  output  1  detonator trigger pulse.
REQ-012 SHALL have busy  output  1  high in any state other than IDLE.
REQ-013 SHALL have done  output  1  one-cycle pulse on successful wire_sensor capture.
REQ-014 SHALL have fault  output  2  sticky fault code: 0 none, 1 NO_PHASE, 2 WIRE_TIMEOUT, 3 ABORTED.
REQ-015 SHALL have delay_cycles  output  32  trigger-to-wire_sensor delay, in clk cycles.

Function
REQ-016 All async inputs SHALL pass a 2-FF synchronizer; edges SHALL be detected on the synchronized value (3-cycle worst-case input latency).
REQ-017 FSM states SHALL be IDLE, ARMED, WAIT_PHASE, FIRE, WAIT_WIRE.
REQ-018 IDLE -> ARMED on start_condition rising edge; fault SHALL clear on this transition.
REQ-019 ARMED -> WAIT_PHASE on fast_gate rising edge; a gate already open at arming SHALL NOT count (wait for next rising edge).
REQ-020 WAIT_PHASE -> FIRE on phase_signal rising edge while synchronized fast_gate high; phase edge and gate fall in the same cycle SHALL count as a miss.
REQ-021 WAIT_PHASE -> ARMED on fast_gate falling edge with no phase edge; retry counter +1; on reaching GATE_RETRY -> IDLE, fault=NO_PHASE.
REQ-022 output_trigger SHALL assert the cycle after the qualifying phase edge and stay high exactly TRIG_PULSE_CYC cycles; FIRE -> WAIT_WIRE at pulse end.
REQ-023 delay counter SHALL reset to 0 on the first cycle output_trigger is high and increment every cycle until wire_sensor rising edge.
REQ-024 WAIT_WIRE -> IDLE on wire_sensor rising edge: delay_cycles latched, done pulsed one cycle.
REQ-025 WAIT_WIRE -> IDLE when counter reaches WIRE_TIMEOUT_CYC: fault=WIRE_TIMEOUT, delay_cycles=0xFFFF_FFFF.
REQ-026 wire_sensor edges during FIRE SHALL be ignored (not a capture).
REQ-027 start_condition while busy SHALL be ignored.
REQ-028 abort high in any non-IDLE state SHALL -> IDLE next cycle, deassert output_trigger immediately, fault=ABORTED; abort in IDLE has no effect.
REQ-029 delay_cycles SHALL hold its value until the next capture or timeout.

Reset
REQ-030 rst_n low SHALL asynchronously force IDLE, output_trigger=0, busy=0, done=0, fault=0, delay_cycles=0, counters and synchronizers=0.
REQ-031 Reset mid-FIRE SHALL truncate the trigger pulse in the same instant; no trigger SHALL follow reset release without a fresh start_condition edge.

Structure
REQ-032 State enum, fault code constants and default parameter values SHALL live in shared package sync_pkg.
REQ-033 Synchronizer plus rise/fall detect SHALL be one sub-module sync_edge, instantiated once per async input.

Verification
REQ-034 Nominal: gate 100 us every 10 ms, phase 819 kHz, start at 25 ms, wire_sensor 5 ms after trigger -> one 100 ns trigger inside the next gate, done pulse, delay_cycles 500_000 ±3.
REQ-035 Phase held low, GATE_RETRY=4 -> no trigger, fault=NO_PHASE after the 4th gate falls, busy low.
REQ-036 wire_sensor never asserted -> fault=WIRE_TIMEOUT exactly 1_000_000 cycles after trigger start, delay_cycles=0xFFFF_FFFF.
REQ-037 abort asserted 3 cycles into FIRE -> trigger pulse 3–4 cycles long, fault=ABORTED, IDLE next cycle.
REQ-038 rst_n pulsed low in WAIT_WIRE, second start_condition while busy -> all outputs 0, second start ignored, fresh start after reset re-runs nominal sequence.
